// File: rtl/sm_1153_adc_arbiter.sv
// sm_1153_adc_arbiter: shares one ADC conversion engine between a periodic
// line-sensor scan (channels 5/6/7) and two requesters. Grants rotate
// round-robin in the order scan -> req0 -> req1. The requester granted last
// has the lowest priority next time.
//
// Ports:
//   clk_50, rst_n           clock, asynchronous active-low reset
//   req0/req1, ch0/ch1      conversion requests and their ADC channels
//   ack0/ack1, rdata, rerr  one-cycle result strobe, data and timeout flag
//   scan_en                 enables the periodic scan timer
//   conv_start, conv_ch     start pulse and channel to the ADC engine
//   conv_done, conv_data    completion strobe and result from the engine
//   line_ch5/6/7, line_bits latest scan values and their dark/bright bits
//   scan_valid, scan_err    scan-complete strobe and any-timeout flag
//   busy                    high whenever the FSM is not idle
module sm_1153_adc_arbiter #(
  parameter int unsigned SCAN_PERIOD = 50000,
  parameter int unsigned TIMEOUT     = 400,
  parameter logic [11:0] THRESH      = 12'd1500
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  ch0,
  input  logic [2:0]  ch1,
  output logic        ack0,
  output logic        ack1,
  output logic [11:0] rdata,
  output logic        rerr,
  input  logic        scan_en,
  output logic        conv_start,
  output logic [2:0]  conv_ch,
  input  logic        conv_done,
  input  logic [11:0] conv_data,
  output logic [11:0] line_ch5,
  output logic [11:0] line_ch6,
  output logic [11:0] line_ch7,
  output logic [2:0]  line_bits,
  output logic        scan_valid,
  output logic        scan_err,
  output logic        busy
);

  localparam int unsigned TW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;
  typedef enum logic [1:0] {G_SCAN, G_REQ0, G_REQ1} grant_t;

  state_t          state;
  grant_t          grant;
  grant_t          last_g;
  grant_t          pick_c;
  logic            pick_vld_c;
  logic [TW-1:0]   timer;
  logic            scan_tick_c;
  logic            scan_pending;
  logic [WW-1:0]   wait_cnt;
  logic            wait_to_c;
  logic [1:0]      scan_idx;
  logic            scan_err_acc;
  logic            res_err_c;
  logic [11:0]     res_data_c;

  // Scan period timer; scan_en low holds it at zero.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (!scan_en || timer == TW'(SCAN_PERIOD - 1)) begin
      timer <= '0;
    end else begin
      timer <= TW'(timer + TW'(1));
    end
  end

  assign scan_tick_c = scan_en && (timer == TW'(SCAN_PERIOD - 1));

  // Round-robin pick: search starts just after the last granted requester.
  always_comb begin
    pick_c     = G_SCAN;
    pick_vld_c = 1'b1;
    case (last_g)
      G_SCAN: begin
        if (req0)              pick_c = G_REQ0;
        else if (req1)         pick_c = G_REQ1;
        else if (scan_pending) pick_c = G_SCAN;
        else                   pick_vld_c = 1'b0;
      end
      G_REQ0: begin
        if (req1)              pick_c = G_REQ1;
        else if (scan_pending) pick_c = G_SCAN;
        else if (req0)         pick_c = G_REQ0;
        else                   pick_vld_c = 1'b0;
      end
      default: begin
        if (scan_pending)      pick_c = G_SCAN;
        else if (req0)         pick_c = G_REQ0;
        else if (req1)         pick_c = G_REQ1;
        else                   pick_vld_c = 1'b0;
      end
    endcase
  end

  // Completion on the final timeout cycle still counts as success.
  assign wait_to_c  = (wait_cnt == WW'(TIMEOUT - 1));
  assign res_err_c  = ~conv_done;
  assign res_data_c = conv_done ? conv_data : 12'd0;

  // Main FSM with registered strobes and result outputs.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant        <= G_SCAN;
      last_g       <= G_REQ1;
      scan_pending <= 1'b0;
      wait_cnt     <= '0;
      scan_idx     <= 2'd0;
      scan_err_acc <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata        <= 12'd0;
      rerr         <= 1'b0;
      conv_start   <= 1'b0;
      conv_ch      <= 3'd0;
      line_ch5     <= 12'd0;
      line_ch6     <= 12'd0;
      line_ch7     <= 12'd0;
      line_bits    <= 3'd0;
      scan_valid   <= 1'b0;
      scan_err     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= 12'd0;
      rerr       <= 1'b0;
      scan_valid <= 1'b0;
      scan_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld_c) begin
            grant        <= pick_c;
            last_g       <= pick_c;
            scan_idx     <= 2'd0;
            scan_err_acc <= 1'b0;
            case (pick_c)
              G_REQ0:  conv_ch <= ch0;
              G_REQ1:  conv_ch <= ch1;
              default: conv_ch <= 3'd5;
            endcase
            conv_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (conv_done || wait_to_c) begin
            state <= DELIVER;
            case (grant)
              G_REQ0: begin
                ack0  <= 1'b1;
                rdata <= res_data_c;
                rerr  <= res_err_c;
              end
              G_REQ1: begin
                ack1  <= 1'b1;
                rdata <= res_data_c;
                rerr  <= res_err_c;
              end
              default: begin
                if (conv_done) begin
                  case (scan_idx)
                    2'd0:    begin line_ch5 <= conv_data; line_bits[0] <= conv_data > THRESH; end
                    2'd1:    begin line_ch6 <= conv_data; line_bits[1] <= conv_data > THRESH; end
                    default: begin line_ch7 <= conv_data; line_bits[2] <= conv_data > THRESH; end
                  endcase
                end
                scan_err_acc <= scan_err_acc | res_err_c;
                if (scan_idx == 2'd2) begin
                  scan_valid   <= 1'b1;
                  scan_err     <= scan_err_acc | res_err_c;
                  scan_pending <= 1'b0;
                end
              end
            endcase
          end else begin
            wait_cnt <= WW'(wait_cnt + WW'(1));
          end
        end
        default: begin
          // Scan continues straight to the next channel without re-arbitrating.
          if (grant == G_SCAN && scan_idx != 2'd2) begin
            scan_idx   <= 2'(scan_idx + 2'd1);
            conv_ch    <= 3'(conv_ch + 3'd1);
            conv_start <= 1'b1;
            state      <= ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
      // A new period expiring wins over the end-of-scan clear.
      if (scan_tick_c) scan_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sm_1153_adc_arbiter.sv
// Self-checking bench for sm_1153_adc_arbiter. At each grant the reference
// model plans the whole transaction timeline (start, engine response,
// delivery) into per-cycle expectation tables, and the engine stub replays
// the planned conv_done strobes. The DUT is compared every cycle.
`timescale 1ns/1ps
module tb_sm_1153_adc_arbiter;

  localparam int unsigned SP   = 100;
  localparam int          TO   = 40;
  localparam logic [11:0] TH   = 12'd1500;
  localparam int          MAXC = 9000;

  logic        clk_50 = 1'b0;
  logic        rst_n  = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, scan_en = 1'b0, conv_done = 1'b0;
  logic [2:0]  ch0 = 3'd0, ch1 = 3'd0;
  logic [11:0] conv_data = 12'd0;
  logic        ack0, ack1, rerr, conv_start, scan_valid, scan_err, busy;
  logic [11:0] rdata, line_ch5, line_ch6, line_ch7;
  logic [2:0]  conv_ch, line_bits;

  always #10 clk_50 = ~clk_50;

  sm_1153_adc_arbiter #(.SCAN_PERIOD(SP), .TIMEOUT(TO), .THRESH(TH)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .req0(req0), .req1(req1), .ch0(ch0), .ch1(ch1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .rerr(rerr), .scan_en(scan_en),
    .conv_start(conv_start), .conv_ch(conv_ch), .conv_done(conv_done),
    .conv_data(conv_data), .line_ch5(line_ch5), .line_ch6(line_ch6),
    .line_ch7(line_ch7), .line_bits(line_bits), .scan_valid(scan_valid),
    .scan_err(scan_err), .busy(busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Expectation tables indexed by cycle.
  bit          e_start [MAXC];
  bit          e_busy  [MAXC];
  bit          e_ack0  [MAXC];
  bit          e_ack1  [MAXC];
  bit          e_rerr  [MAXC];
  bit          e_sv    [MAXC];
  bit          e_se    [MAXC];
  logic [2:0]  e_ch    [MAXC];
  logic [11:0] e_rdata [MAXC];
  int          u_k     [MAXC];
  logic [11:0] u_v     [MAXC];
  // Engine stub schedule.
  bit          dn_v    [MAXC];
  logic [11:0] dn_d    [MAXC];

  // Reference model state.
  int          m_timer = 0;
  bit          m_pend = 1'b0;
  int          m_last = 2;
  int          m_busy_end = 0;
  int          m_clr = -1;
  logic [11:0] m_line [3];
  int          f_lat [$];
  logic [11:0] f_dat [$];

  // Observations for directed checks.
  int          a_log [$];
  logic [11:0] last_rd = 12'd0;
  logic        last_rerr = 1'b0;
  logic        last_serr = 1'b0;
  int          n_scan = 0;
  bit          want_first = 1'b0;
  logic [2:0]  first_ch = 3'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Engine response choice; -1 means the engine never answers.
  task automatic pick_resp(output int lat, output logic [11:0] d);
    if (f_lat.size() > 0) begin
      lat = f_lat.pop_front();
      d   = f_dat.pop_front();
    end else begin
      case ($urandom_range(0, 9))
        0:       lat = TO;
        1:       lat = TO + 1;
        2:       lat = -1;
        3:       lat = 1;
        default: lat = int'($urandom_range(2, 25));
      endcase
      d = 12'($urandom);
    end
  endtask

  // Plan a full grant: who 0=scan, 1=req0, 2=req1; granted in idle cycle g.
  task automatic plan(input int g, input int who, input logic [2:0] ch);
    int s, d, lat, nconv;
    logic [11:0] v;
    bit err, eany;
    s = g + 1; d = g; eany = 1'b0;
    nconv = (who == 0) ? 3 : 1;
    for (int k = 0; k < nconv; k++) begin
      pick_resp(lat, v);
      if (lat >= 1 && lat <= TO) begin d = s + lat + 1; err = 1'b0; end
      else begin d = s + TO + 1; err = 1'b1; end
      if (lat >= 1) begin dn_v[s + lat] = 1'b1; dn_d[s + lat] = v; end
      if (!dn_v[d] && $urandom_range(0, 1) == 1) begin
        dn_v[d] = 1'b1; dn_d[d] = 12'($urandom);
      end
      e_start[s] = 1'b1;
      for (int t = s; t <= d; t++) begin
        e_busy[t] = 1'b1;
        e_ch[t]   = (who == 0) ? 3'(5 + k) : ch;
      end
      if (who == 0) begin
        if (!err) begin u_k[d] = k + 1; u_v[d] = v; end
        eany = eany | err;
        if (k == 2) begin e_sv[d] = 1'b1; e_se[d] = eany; m_clr = d; end
      end else begin
        if (who == 1) e_ack0[d] = 1'b1; else e_ack1[d] = 1'b1;
        e_rdata[d] = err ? 12'd0 : v;
        e_rerr[d]  = err;
      end
      s = d + 1;
    end
    m_busy_end = d;
  endtask

  // Model evaluation of cycle n using the inputs driven during it.
  task automatic model_step(input int n);
    bit rq [3];
    bit found;
    int w;
    bit set;
    rq[0] = m_pend; rq[1] = req0; rq[2] = req1;
    found = 1'b0;
    if (n > m_busy_end) begin
      for (int i = 1; i <= 3; i++) begin
        w = (m_last + i) % 3;
        if (!found && rq[w]) begin
          found = 1'b1;
          plan(n, w, (w == 1) ? ch0 : ch1);
          m_last = w;
        end
      end
    end
    set = scan_en && (m_timer == int'(SP) - 1);
    if (!scan_en || set) m_timer = 0; else m_timer = m_timer + 1;
    if (n + 1 == m_clr) m_pend = 1'b0;
    if (set) m_pend = 1'b1;
  endtask

  task automatic model_reset(input int n);
    for (int t = n + 1; t < MAXC; t++) begin
      e_start[t] = 0; e_busy[t] = 0; e_ack0[t] = 0; e_ack1[t] = 0; e_rerr[t] = 0;
      e_sv[t] = 0; e_se[t] = 0; e_ch[t] = 3'd0; e_rdata[t] = 12'd0; u_k[t] = 0;
    end
    m_timer = 0; m_pend = 1'b0; m_last = 2; m_busy_end = n; m_clr = -1;
    for (int k = 0; k < 3; k++) m_line[k] = 12'd0;
  endtask

  task automatic check_outputs(input int n);
    if (u_k[n] != 0) m_line[u_k[n] - 1] = u_v[n];
    chk("ctl", 32'({conv_start, ack0, ack1, rerr, busy, scan_valid, scan_err}),
        32'({e_start[n], e_ack0[n], e_ack1[n], e_rerr[n], e_busy[n], e_sv[n], e_se[n]}));
    chk("rdata", 32'(rdata), 32'(e_rdata[n]));
    if (e_busy[n] || !rst_n) chk("conv_ch", 32'(conv_ch), 32'(e_ch[n]));
    chk("line5", 32'(line_ch5), 32'(m_line[0]));
    chk("line6", 32'(line_ch6), 32'(m_line[1]));
    chk("line7", 32'(line_ch7), 32'(m_line[2]));
    chk("line_bits", 32'(line_bits), 32'({m_line[2] > TH, m_line[1] > TH, m_line[0] > TH}));
    if (ack0) a_log.push_back(0);
    if (ack1) a_log.push_back(1);
    if (ack0 || ack1) begin last_rd = rdata; last_rerr = rerr; end
    if (scan_valid) begin n_scan++; last_serr = scan_err; end
    if (conv_start && want_first) begin first_ch = conv_ch; want_first = 1'b0; end
  endtask

  task automatic tick(input logic r0, input logic r1, input logic [2:0] c0,
                      input logic [2:0] c1, input logic se);
    @(posedge clk_50);
    cyc++;
    #1;
    if (cyc >= MAXC - 200) begin
      $display("FAIL cycle_budget cyc=%0d got=over want=under", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    check_outputs(cyc);
    req0 = r0; req1 = r1; ch0 = c0; ch1 = c1; scan_en = se;
    conv_done = dn_v[cyc];
    conv_data = dn_v[cyc] ? dn_d[cyc] : 12'($urandom);
    if (rst_n) model_step(cyc);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; scan_en = 1'b0;
    #1;
    chk("rst_ctl", 32'({conv_start, ack0, ack1, rerr, busy, scan_valid, scan_err}), 32'd0);
    chk("rst_data", 32'({rdata, conv_ch, line_bits}), 32'd0);
    chk("rst_lines", 32'({line_ch5, line_ch6}), 32'd0);
    chk("rst_line7", 32'(line_ch7), 32'd0);
    model_reset(cyc);
    f_lat.delete(); f_dat.delete();
    repeat (3) tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic se;
    int base;
    for (int k = 0; k < 3; k++) m_line[k] = 12'd0;
    #2;
    apply_reset();
    repeat (3) tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0);

    // Single req0 conversion, engine answers 20 cycles after start.
    a_log.delete();
    f_lat.push_back(20); f_dat.push_back(12'hABC);
    tick(1'b1, 1'b0, 3'd3, 3'd0, 1'b0);
    repeat (30) tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    chk("031_nack", 32'(a_log.size()), 32'd1);
    chk("031_rdata", 32'(last_rd), 32'hABC);

    // Engine silent: timeout, then a normal request from req1.
    f_lat.push_back(-1); f_dat.push_back(12'd0);
    tick(1'b0, 1'b1, 3'd0, 3'd2, 1'b0);
    repeat (45) tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    chk("034_rerr", 32'(last_rerr), 32'd1);
    chk("034_rdata", 32'(last_rd), 32'd0);
    f_lat.push_back(5); f_dat.push_back(12'h123);
    tick(1'b0, 1'b1, 3'd0, 3'd1, 1'b0);
    repeat (12) tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    chk("034_next", 32'({last_rerr, last_rd}), 32'({1'b0, 12'h123}));

    // Both requesters held: grants alternate starting with req0.
    a_log.delete();
    repeat (3) begin f_lat.push_back(3); f_dat.push_back(12'($urandom)); end
    repeat (16) tick(1'b1, 1'b1, 3'd1, 3'd2, 1'b0);
    repeat (20) tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    chk("032_cnt", 32'(a_log.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++)
      chk("032_order", 32'((i < a_log.size()) ? a_log[i] : 9), 32'(i % 2));

    // Periodic scan with a fixed dark/bright/dark pattern.
    base = n_scan;
    f_lat.push_back(6); f_dat.push_back(12'd2730);
    f_lat.push_back(9); f_dat.push_back(12'd223);
    f_lat.push_back(4); f_dat.push_back(12'd2730);
    repeat (150) tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b1);
    repeat (5) tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    chk("033_bits", 32'(line_bits), 32'b101);
    chk("033_nscan", 32'(n_scan - base), 32'd1);
    chk("033_serr", 32'(last_serr), 32'd0);

    // Reset during WAIT; the late conv_done must be ignored afterwards.
    f_lat.push_back(30); f_dat.push_back(12'h5A5);
    tick(1'b1, 1'b0, 3'd2, 3'd0, 1'b0);
    repeat (6) tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    apply_reset();
    for (int i = 0; i < 300 && !m_pend; i++) tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b1);
    chk("035_pending", 32'(m_pend), 32'd1);
    want_first = 1'b1;
    repeat (150) tick(1'b1, 1'b0, 3'd4, 3'd0, 1'b0);
    chk("035_first_ch", 32'(first_ch), 32'd5);
    repeat (60) tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0);

    // Randomized traffic.
    se = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if (i % 200 == 0) se = ($urandom_range(0, 3) != 0);
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           3'($urandom), 3'($urandom), se);
    end
    repeat (300) tick(1'b0, 1'b0, 3'd0, 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
